// File: rtl/clken_pkg.sv
// rtl/clken_pkg.sv - shared types, constants and increment helper for frac_clken_gen
// Contents:
//   state_t   : sequencer states (SETTLE, LOCKED)
//   CH_IDX_W  : width of the channel index on the cfg interface
//   calc_inc  : rounded phase increment for a target enable rate
package clken_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CH_IDX_W = 4;

  // round(f_out * 2^acc_w / f_ref); adding f_ref/2 before the divide rounds to nearest
  function automatic logic [63:0] calc_inc(input logic [63:0] f_ref_hz,
                                           input logic [63:0] f_out_hz,
                                           input int          acc_w);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

endpackage

// File: rtl/frac_clken_gen_if.sv
// rtl/frac_clken_gen_if.sv - cfg handshake, realign and enable outputs of frac_clken_gen
// Signals:
//   cfg_valid/cfg_ch/cfg_inc : rate change request (master -> slave)
//   cfg_ready                : request accepted this cycle when high with cfg_valid
//   cfg_err                  : one-cycle pulse for an accepted out-of-range channel
//   realign                  : one-cycle pulse zeroing all phase accumulators
//   clken                    : per-channel one-cycle enable pulses
//   locked                   : enables are valid
interface frac_clken_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32
) ();
  import clken_pkg::*;

  logic                cfg_valid;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [ACC_W-1:0]    cfg_inc;
  logic                cfg_ready;
  logic                cfg_err;
  logic                realign;
  logic [NUM_CH-1:0]   clken;
  logic                locked;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, realign,
    input  cfg_ready, cfg_err, clken, locked
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, realign,
    output cfg_ready, cfg_err, clken, locked
  );

endinterface

// File: rtl/phase_acc_channel.sv
// rtl/phase_acc_channel.sv - one fractional phase accumulator with loadable increment
// Ports:
//   refclk   : clock
//   rst      : asynchronous active-high reset (acc=0, inc=INIT_INC)
//   run      : advance the accumulator by inc this cycle
//   clear    : zero the accumulator (wins over run)
//   inc_load : replace the increment with inc_in
//   inc_in   : new increment
//   carry_q  : registered carry out of the add that just wrapped
module phase_acc_channel #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_in,
  output logic             carry_q
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             carry_d;

  always_comb begin
    inc_d   = inc_load ? inc_in : inc_q;
    acc_d   = acc_q;
    carry_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      inc_q   <= INIT_INC;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/frac_clken_gen.sv
// rtl/frac_clken_gen.sv - multi-channel fractional clock-enable generator with lock sequencer
// Ports:
//   refclk : sole clock, all logic on its rising edge
//   rst    : asynchronous active-high reset
//   bus    : slave side of frac_clken_gen_if (cfg handshake, realign, clken, locked)
module frac_clken_gen
  import clken_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {NUM_CH{ACC_W'(calc_inc(64'd2, 64'd1, ACC_W))}}
) (
  input logic             refclk,
  input logic             rst,
  frac_clken_gen_if.slave bus
);

  localparam int             CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam int             CH_CMP_W = CH_IDX_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic              locked_q, locked_d;
  logic              en_q, en_d;
  logic              cfg_err_q, cfg_err_d;
  logic              accept, ch_ok, cfg_write, relock, clear_acc, run;
  logic [NUM_CH-1:0] inc_load;
  logic [NUM_CH-1:0] carry_q;

  // cfg_ready is the registered locked flag, so acceptance is only possible in LOCKED
  always_comb begin
    accept    = locked_q & bus.cfg_valid;
    ch_ok     = {1'b0, bus.cfg_ch} < CH_CMP_W'(NUM_CH);
    cfg_write = accept & ch_ok;
    relock    = (state_q == LOCKED) & (cfg_write | bus.realign);
    clear_acc = cfg_write | bus.realign;
    run       = (state_q == SETTLE) | (state_q == LOCKED);
    inc_load  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc_load[i] = cfg_write & (bus.cfg_ch == CH_IDX_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      SETTLE: begin
        if (bus.realign) begin
          settle_cnt_d = '0;
        end else if (settle_cnt_q == CNT_LAST) begin
          state_d      = LOCKED;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (relock) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      default: state_d = SETTLE;
    endcase
    locked_d  = (state_d == LOCKED);
    // Carries are only passed once LOCKED was already the state at the edge producing them,
    // and a relock edge silences the very next cycle.
    en_d      = (state_q == LOCKED) & ~relock;
    cfg_err_d = accept & ~ch_ok;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      locked_q     <= 1'b0;
      en_q         <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      locked_q     <= locked_d;
      en_q         <= en_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    phase_acc_channel #(
      .ACC_W    (ACC_W),
      .INIT_INC (INIT_INC[g*ACC_W +: ACC_W])
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .run      (run),
      .clear    (clear_acc),
      .inc_load (inc_load[g]),
      .inc_in   (bus.cfg_inc),
      .carry_q  (carry_q[g])
    );
  end

  // Both operands are flops updated on the same edge, so clken is a registered pulse
  assign bus.clken     = carry_q & {NUM_CH{en_q}};
  assign bus.locked    = locked_q;
  assign bus.cfg_ready = locked_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb/tb_frac_clken_gen.sv - self-checking bench for frac_clken_gen
module tb_frac_clken_gen;

  localparam int                      NUM_CH = 2;
  localparam int                      ACC_W  = 8;
  localparam int                      LOCK   = 16;
  localparam logic [NUM_CH*ACC_W-1:0] INIT   = {8'h40, 8'h80};

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   errors = 0;
  int   checks = 0;

  frac_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  frac_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK),
    .INIT_INC    (INIT)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: m_since counts adds since the accumulators were last zeroed; the rate
  // increment only changes at such a zeroing, so acc = m_since*inc mod 2^ACC_W.
  int                m_since = 0;
  int                m_inc [NUM_CH];
  bit                m_err = 1'b0;
  bit                m_accept;
  bit                m_in_range;
  logic [NUM_CH-1:0] exp_ck;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_since = 0;
      m_err   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_inc[i] = int'(INIT[i*ACC_W +: ACC_W]);
    end else begin
      m_accept   = bus.cfg_valid && (m_since >= LOCK);
      m_in_range = int'(bus.cfg_ch) < NUM_CH;
      m_err      = m_accept && !m_in_range;
      if (m_accept && m_in_range) m_inc[int'(bus.cfg_ch)] = int'(bus.cfg_inc);
      if ((m_accept && m_in_range) || bus.realign) m_since = 0;
      else m_since++;
    end
  end

  // A pulse is due when add number 'since' crossed a multiple of 2^ACC_W, except in
  // the first LOCKED cycle (since == LOCK) and throughout settling.
  function automatic bit exp_pulse(input int since, input int inc);
    if (since <= LOCK) return 1'b0;
    return ((since * inc) >> ACC_W) != (((since - 1) * inc) >> ACC_W);
  endfunction

  always @(negedge refclk) begin
    for (int i = 0; i < NUM_CH; i++) exp_ck[i] = exp_pulse(m_since, m_inc[i]);
    check("clken", 32'(bus.clken), 32'(exp_ck));
    check("locked", 32'(bus.locked), 32'(m_since >= LOCK));
    check("cfg_ready", 32'(bus.cfg_ready), 32'(m_since >= LOCK));
    check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
  end

  task automatic send(input logic [3:0] ch, input logic [7:0] inc, input logic valid, input logic ra);
    bus.cfg_valid = valid;
    bus.cfg_ch    = ch;
    bus.cfg_inc   = inc;
    bus.realign   = ra;
    @(negedge refclk);
    bus.cfg_valid = 1'b0;
    bus.realign   = 1'b0;
  endtask

  task automatic wait_locked(output int n, output int early);
    n     = 0;
    early = 0;
    while (bus.locked !== 1'b1 && n < 200) begin
      @(negedge refclk);
      n++;
      if (bus.locked !== 1'b1 && bus.clken != '0) early++;
    end
    if (bus.locked !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_locked: locked still low after %0d cycles", n);
    end
  endtask

  task automatic count_pulses(input int cycles, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge refclk);
      if (bus.clken[0]) c0++;
      if (bus.clken[1]) c1++;
    end
  endtask

  task automatic first_pulses(output int f0, output int f1);
    f0 = -1;
    f1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge refclk);
      if (f0 < 0 && bus.clken[0]) f0 = k;
      if (f1 < 0 && bus.clken[1]) f1 = k;
    end
  endtask

  initial begin
    int n, early, c0, c1, f0, f1;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_inc   = '0;
    bus.realign   = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_locked", 32'(bus.locked), 0);
    check("reset_clken", 32'(bus.clken), 0);

    // Lock after reset, default rates
    rst = 1'b0;
    wait_locked(n, early);
    check("s1_lock_latency", n, 16);
    check("s1_unlocked_pulses", early, 0);
    count_pulses(16, c0, c1);
    check("s1_ch0_in_16", c0, 8);
    check("s1_ch1_in_16", c1, 4);

    // Realign twice, second one mid-settle
    send(4'd0, 8'h00, 1'b0, 1'b1);
    check("s5_drop", 32'(bus.locked), 0);
    repeat (9) @(negedge refclk);
    check("s5_mid_settle", 32'(bus.locked), 0);
    send(4'd0, 8'h00, 1'b0, 1'b1);
    wait_locked(n, early);
    check("s5_lock_latency", n, 16);
    first_pulses(f0, f1);
    check("s5_ch0_first", f0, 2);
    check("s5_ch1_first", f1, 4);

    // ch1 to 0x55
    send(4'd1, 8'h55, 1'b1, 1'b0);
    check("s2_drop", 32'(bus.locked), 0);
    wait_locked(n, early);
    check("s2_lock_latency", n, 16);
    count_pulses(256, c0, c1);
    check("s2_ch0_in_256", c0, 128);
    check("s2_ch1_in_256", c1, 85);

    // Out-of-range channel
    send(4'd5, 8'h10, 1'b1, 1'b0);
    check("s3_err_pulse", 32'(bus.cfg_err), 1);
    check("s3_stays_locked", 32'(bus.locked), 1);
    @(negedge refclk);
    check("s3_err_one_cycle", 32'(bus.cfg_err), 0);
    count_pulses(256, c0, c1);
    check("s3_ch0_in_256", c0, 128);
    check("s3_ch1_in_256", c1, 85);

    // ch0 to zero, then to full scale
    send(4'd0, 8'h00, 1'b1, 1'b0);
    wait_locked(n, early);
    check("s4a_lock_latency", n, 16);
    count_pulses(256, c0, c1);
    check("s4a_ch0_in_256", c0, 0);
    check("s4a_ch1_in_256", c1, 85);
    send(4'd0, 8'hFF, 1'b1, 1'b0);
    wait_locked(n, early);
    check("s4b_lock_latency", n, 16);
    count_pulses(256, c0, c1);
    check("s4b_ch0_in_256", c0, 255);

    // Valid cfg together with realign: one relock
    send(4'd1, 8'h20, 1'b1, 1'b1);
    check("sim_drop", 32'(bus.locked), 0);
    wait_locked(n, early);
    check("sim_lock_latency", n, 16);
    first_pulses(f0, f1);
    check("sim_ch0_first", f0, 1);
    check("sim_ch1_first", f1, 8);

    // Asynchronous reset mid-LOCKED
    #2 rst = 1'b1;
    #1;
    check("s6_locked_now", 32'(bus.locked), 0);
    check("s6_ready_now", 32'(bus.cfg_ready), 0);
    check("s6_clken_now", 32'(bus.clken), 0);
    @(negedge refclk);
    rst = 1'b0;
    wait_locked(n, early);
    check("s6_lock_latency", n, 16);
    first_pulses(f0, f1);
    check("s6_ch0_first", f0, 2);
    check("s6_ch1_first", f1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
